spi_rr_scheduler: RTL and testbench

Round-robin scheduler that shares the single 8-bit mode-0 SPI master between NREQ requesters. It latches the winning requester's byte, issues a one-cycle start to the master, and waits for the master's done. It then acknowledges the requester and enforces a minimum SS-high gap before the next transfer. A watchdog aborts a transfer whose done never arrives.

---
 rtl/spi_rr_scheduler.sv | 156 +++++++++++++++
 tb/tb_spi_rr_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rr_scheduler.sv
// Round-robin scheduler sharing one 8-bit SPI master among NREQ requesters.
// Latches the winner's byte, pulses start, waits for done (with watchdog), acks, then holds an SS-high gap.
module spi_rr_scheduler #(
   parameter int NREQ    = 4,
   parameter int GAP     = 2,
   parameter int TIMEOUT = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   ack,
   output logic [2:0]        cur_id,
   output logic              spi_start,
   output logic [7:0]        spi_data,
   input  logic              spi_done,
   output logic              busy,
   output logic              timeout_err
);

   // state   | meaning
   // S_IDLE  | no transfer; arbitrate and latch winner when any req is high
   // S_ISSUE | spi_start high for exactly this cycle
   // S_GUARD | master is clearing its previous done; spi_done ignored
   // S_BUSY  | waiting for spi_done while the watchdog counts down
   // S_GAP   | SS-high spacing before the next arbitration
   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_GUARD,
      S_BUSY,
      S_GAP
   } state_t;

   localparam int TMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] WDOG_LOAD = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP - 1);
   localparam logic [TW-1:0] TMR_ONE   = TW'(1);

   state_t          state;
   state_t          state_nxt;
   logic [TW-1:0]   tmr;
   logic            tmr_tc;
   logic [2:0]      ptr;
   logic            win_valid;
   logic [2:0]      win_id;
   logic [7:0]      win_data;
   logic [NREQ-1:0] win_grant;
   logic [7:0]      req_ext;
   logic [3:0]      scan;

   assign tmr_tc  = (tmr == '0);
   assign req_ext = 8'(req);

   // Search starts at ptr and wraps at NREQ; first requester found wins.
   always_comb begin
      win_valid = 1'b0;
      win_id    = '0;
      scan      = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan = {1'b0, ptr} + 4'(k);
         if (scan >= 4'(NREQ)) begin
            scan = scan - 4'(NREQ);
         end
         if (!win_valid && req_ext[scan[2:0]]) begin
            win_valid = 1'b1;
            win_id    = scan[2:0];
         end
      end
   end

   always_comb begin
      win_data  = '0;
      win_grant = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_id == 3'(i)) begin
            win_data     = req_data[8*i +: 8];
            win_grant[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (win_valid) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_GUARD;
         S_GUARD: state_nxt = S_BUSY;
         S_BUSY:  if (spi_done || tmr_tc) state_nxt = S_GAP;
         S_GAP:   if (tmr_tc) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      spi_start = (state == S_ISSUE);
      busy      = (state != S_IDLE);
   end

   // One down-counter serves both the BUSY watchdog and the GAP spacing.
   always_ff @(posedge clk) begin
      if (!rst) begin
         grant       <= '0;
         ack         <= '0;
         cur_id      <= '0;
         spi_data    <= '0;
         timeout_err <= 1'b0;
         ptr         <= '0;
         tmr         <= '0;
      end else begin
         ack <= '0;
         case (state)
            S_IDLE: begin
               if (win_valid) begin
                  grant    <= win_grant;
                  cur_id   <= win_id;
                  spi_data <= win_data;
               end
            end
            S_GUARD: begin
               tmr <= WDOG_LOAD;
            end
            S_BUSY: begin
               if (spi_done || tmr_tc) begin
                  ack   <= grant;
                  grant <= '0;
                  tmr   <= GAP_LOAD;
                  ptr   <= (cur_id == 3'(NREQ - 1)) ? 3'd0 : cur_id + 3'd1;
                  if (!spi_done) begin
                     timeout_err <= 1'b1;
                  end
               end else begin
                  tmr <= tmr - TMR_ONE;
               end
            end
            S_GAP: begin
               if (!tmr_tc) begin
                  tmr <= tmr - TMR_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_rr_scheduler.sv
// Testbench for spi_rr_scheduler: directed and randomized transfers against a transaction-level
// round-robin model plus a simple SPI master model with programmable done latency.
module tb_spi_rr_scheduler;
   localparam int NREQ    = 4;
   localparam int GAP     = 2;
   localparam int TIMEOUT = 40;
   localparam int NOM     = 18;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [8*NREQ-1:0] req_data = '0;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   ack;
   logic [2:0]        cur_id;
   logic              spi_start;
   logic [7:0]        spi_data;
   logic              spi_done = 1'b0;
   logic              busy;
   logic              timeout_err;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int mptr = 0;
   bit m_terr = 1'b0;

   int done_delay = NOM;
   bit done_off = 1'b0;
   int mcnt = 0;
   bit mact = 1'b0;

   bit              mon_en = 1'b0;
   int              mon_bad = 0;
   logic [NREQ-1:0] prev_ack = '0;
   logic            prev_start = 1'b0;

   spi_rr_scheduler #(.NREQ(NREQ), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .grant       (grant),
      .ack         (ack),
      .cur_id      (cur_id),
      .spi_start   (spi_start),
      .spi_data    (spi_data),
      .spi_done    (spi_done),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // SPI master model: done clears on start and rises done_delay cycles after the start cycle.
   always @(posedge clk) begin
      if (!rst) begin
         spi_done <= 1'b0;
         mcnt     <= 0;
         mact     <= 1'b0;
      end else if (spi_start) begin
         spi_done <= 1'b0;
         mcnt     <= 1;
         mact     <= 1'b1;
      end else if (mact) begin
         mcnt <= mcnt + 1;
         if (mcnt == done_delay - 1 && !done_off) begin
            spi_done <= 1'b1;
            mact     <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (!$onehot0(grant)) mon_bad = mon_bad + 1;
         if (!$onehot0(ack)) mon_bad = mon_bad + 1;
         if ((ack !== '0) && (prev_ack !== '0)) mon_bad = mon_bad + 1;
         if ((spi_start === 1'b1) && (prev_start === 1'b1)) mon_bad = mon_bad + 1;
      end
      prev_ack   = ack;
      prev_start = spi_start;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1, "bench time limit reached");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [7:0] byte_of(input int i);
      return req_data[8*i +: 8];
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "/grant"}, grant, 0);
      chk({tag, "/ack"}, ack, 0);
      chk({tag, "/cur_id"}, cur_id, 0);
      chk({tag, "/spi_start"}, spi_start, 0);
      chk({tag, "/spi_data"}, spi_data, 0);
      chk({tag, "/busy"}, busy, 0);
      chk({tag, "/timeout_err"}, timeout_err, 0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      req = '0;
      repeat (3) @(negedge clk);
      chk_zero(tag);
      rst    = 1'b1;
      mptr   = 0;
      m_terr = 1'b0;
   endtask

   task automatic wait_start(output int t, output bit ok);
      ok = 1'b0;
      t  = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (spi_start === 1'b1) begin
            ok = 1'b1;
            t  = cyc;
            return;
         end
      end
   endtask

   // One full transfer: start, latency to ack, ack target, error flag, gap length.
   task automatic run_xfer(input string tag, input int exp_id, input logic [7:0] exp_data,
                           input int lat, input bit to_evt, input logic [NREQ-1:0] drop,
                           input bit scramble, output int t);
      bit              ok;
      int              a;
      logic [NREQ-1:0] oh;
      oh     = '0;
      oh[exp_id] = 1'b1;
      wait_start(t, ok);
      chk({tag, "/start_seen"}, 32'(ok), 1);
      if (!ok) return;
      chk({tag, "/grant"}, grant, oh);
      chk({tag, "/cur_id"}, cur_id, exp_id);
      chk({tag, "/spi_data"}, spi_data, exp_data);
      chk({tag, "/busy"}, busy, 1);
      if (scramble) req_data = $urandom;
      a = -1;
      for (int n = 1; n <= lat + 8; n++) begin
         @(negedge clk);
         if (ack !== '0) begin
            a = cyc;
            break;
         end
         if (n == lat - 1) chk({tag, "/terr_before_ack"}, timeout_err, m_terr);
      end
      chk({tag, "/ack_latency"}, a - t, lat);
      if (a < 0) return;
      chk({tag, "/ack"}, ack, oh);
      if (to_evt) m_terr = 1'b1;
      chk({tag, "/timeout_err"}, timeout_err, m_terr);
      chk({tag, "/spi_data_held"}, spi_data, exp_data);
      chk({tag, "/grant_cleared"}, grant, 0);
      req  = req & ~drop;
      mptr = (exp_id + 1) % NREQ;
      repeat (GAP - 1) @(negedge clk);
      chk({tag, "/busy_in_gap"}, busy, 1);
      @(negedge clk);
      chk({tag, "/idle_after_gap"}, busy, 0);
   endtask

   initial begin
      int              t;
      int              tprev;
      int              cset;
      int              id;
      int              d;
      bit              ok;
      logic [NREQ-1:0] r;

      do_reset("reset");
      mon_en = 1'b1;

      // Single request from requester 2 with byte A5; data changes after issue must not leak.
      req_data = $urandom;
      req_data[23:16] = 8'hA5;
      req  = 4'b0100;
      cset = cyc;
      run_xfer("single", 2, 8'hA5, NOM + 1, 1'b0, 4'b0100, 1'b1, t);
      chk("single/arb_latency", t - cset, 1);

      // Pointer now at 3: requester 3 first, then 0 wins over the still-high 3.
      req_data = $urandom;
      req = 4'b1000;
      run_xfer("wrap3", 3, byte_of(3), NOM + 1, 1'b0, 4'b0000, 1'b0, t);
      req = 4'b1001;
      run_xfer("wrap0", 0, byte_of(0), NOM + 1, 1'b0, 4'b1001, 1'b0, t);

      do_reset("reset2");

      // All four held: 0,1,2,3,0 with fixed spacing.
      req_data = 32'h4332_2110;
      req = 4'b1111;
      tprev = 0;
      for (int k = 0; k < 5; k++) begin
         run_xfer($sformatf("rr%0d", k), k % NREQ, byte_of(k % NREQ), NOM + 1, 1'b0,
                  (k == 4) ? 4'b1111 : 4'b0000, 1'b0, t);
         if (k > 0) chk($sformatf("rr%0d/spacing", k), t - tprev, 20 + GAP);
         tprev = t;
      end

      // Random request patterns, bytes and done latencies up to the tie boundary.
      for (int it = 0; it < 16; it++) begin
         req_data   = $urandom;
         r          = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         d          = int'($urandom_range(3, TIMEOUT + 1));
         done_delay = d;
         req        = r;
         id         = pick(r, mptr);
         run_xfer($sformatf("rand%0d", it), id, byte_of(id), d + 1, 1'b0, '1, 1'b0, t);
      end
      done_delay = NOM;

      // Done arriving exactly at watchdog expiry counts as done.
      req_data   = $urandom;
      done_delay = TIMEOUT + 1;
      req        = 4'b0001;
      run_xfer("tie", pick(req, mptr), byte_of(pick(req, mptr)), TIMEOUT + 2, 1'b0, '1, 1'b0, t);
      done_delay = NOM;

      // Watchdog abort, then a normal transfer still served with the error sticky.
      req_data = $urandom;
      done_off = 1'b1;
      req      = 4'b0001;
      run_xfer("wdog", pick(req, mptr), byte_of(pick(req, mptr)), TIMEOUT + 2, 1'b1, '1, 1'b0, t);
      done_off = 1'b0;
      req      = 4'b0010;
      run_xfer("after_wdog", pick(req, mptr), byte_of(pick(req, mptr)), NOM + 1, 1'b0, '1, 1'b0, t);

      // One-cycle reset 8 cycles into a transfer; held request restarts right after.
      req_data = $urandom;
      req      = 4'b0100;
      wait_start(t, ok);
      chk("rst_mid/start_seen", 32'(ok), 1);
      chk("rst_mid/grant", grant, 4'b0100);
      repeat (7) begin
         @(negedge clk);
         chk("rst_mid/no_ack", ack, 0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk_zero("rst_mid");
      rst    = 1'b1;
      mptr   = 0;
      m_terr = 1'b0;
      tprev  = t;
      run_xfer("rst_resume", pick(req, mptr), byte_of(pick(req, mptr)), NOM + 1, 1'b0, '1, 1'b0, t);
      chk("rst_resume/start_cycle", t - tprev, 9);

      req = '0;
      repeat (5) @(negedge clk);
      chk("protocol_onehot_single_pulse", mon_bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
